led_bank_arbiter: RTL
=====================

LED_BANK_ARBITER -- requirements
Module: led_bank_arbiter

Interface
REQ-001 Parameter N_REQ, 4, number of requesters sharing the 8-LED bank.
REQ-002 Parameter HOLD, 4, minimum grant tenure in clock cycles; legal range 1..255.
REQ-003 Parameter IDLE_PATTERN, 8'h00, LED value driven when no requester is granted.
REQ-004 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 Port rst  input  1  reset; one clock, synchronous, active-high.
REQ-006 Port req  input  N_REQ  level request per requester; bit i = requester i.
REQ-007 Port pat  input  8*N_REQ  LED pattern per requester; pat[8i+7:8i] = requester i.
REQ-008 Port gnt  output  N_REQ  registered one-hot grant; all-zero when idle.
REQ-009 Port leds  output  8  registered LED bank drive.
REQ-010 Port active  output  1  high while any grant is held (gnt != 0).

Function
REQ-011 The FSM SHALL have two states: IDLE (gnt=0) and OWN (exactly one gnt bit set).
REQ-012 In IDLE with req != 0 at edge t, the block SHALL enter OWN with gnt set at edge t, visible in cycle t+1.
REQ-013 Winner selection SHALL be round-robin: search starts at index (ptr+1) mod N_REQ, wrapping; ptr = index of last granted requester.
REQ-014 On each grant issue, hold counter SHALL load HOLD-1 and ptr SHALL update to the winner index.
REQ-015 In OWN with counter > 0, counter SHALL decrement by 1 per cycle and gnt SHALL stay unchanged regardless of req.
REQ-016 In OWN with counter == 0: req == 0 -> IDLE, gnt=0; otherwise re-arbitrate per REQ-013 and grant the winner, reloading counter.
REQ-017 Re-arbitration SHALL switch gnt directly between requesters with no idle cycle.
REQ-018 A sole requester still asserting req at counter == 0 SHALL be re-granted (counter reloaded), no gap.
REQ-019 leds SHALL register pat slice of the granted requester each cycle (one-cycle lag after gnt; tracks pat changes during tenure), and IDLE_PATTERN when gnt == 0.
REQ-020 HOLD == 1 SHALL re-arbitrate every cycle.
REQ-021 gnt SHALL never have more than one bit set.

Reset
REQ-022 While rst is high at an edge: state=IDLE, gnt=0, leds=IDLE_PATTERN, active=0, counter=0, ptr=N_REQ-1 (requester 0 wins first).
REQ-023 rst SHALL take priority over every other event, including mid-tenure; release resumes from IDLE on the next edge.

Structure
REQ-024 Shared package led_pkg SHALL hold N_REQ default, IDLE_PATTERN default, and the IDLE/OWN state enum.
REQ-025 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, ptr; outputs one-hot winner, winner index, any).
REQ-026 Counter width SHALL be 8 bits.

Verification (N_REQ=4, HOLD=4, IDLE_PATTERN=8'h00)
REQ-027 rst high 2 cycles, req=4'b1111 -> gnt=0000, leds=8'h00, active=0 throughout; first grant after release is 0001.
REQ-028 req=0010, pat1=8'hA5 from IDLE -> gnt=0010 one cycle later, leds=8'hA5 two cycles later, active=1.
REQ-029 req=1111, pat=0x01/0x02/0x04/0x08 -> gnt sequence 0001,0010,0100,1000,0001, each exactly 4 cycles, no gaps.
REQ-030 req=0001 then dropped after 2 granted cycles -> gnt=0001 for 4 cycles total, then 0000, leds returns to 8'h00 one cycle later.
REQ-031 req=0011 held, rst pulsed 1 cycle during requester 1 tenure -> gnt=0000 next cycle, then 0001 granted (ptr reset), not 0010.
REQ-032 Random req/pat 10k cycles -> assertions: gnt one-hot-or-zero, tenure >= 4 cycles, leds == granted pat one cycle later.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants and state encoding for the LED bank arbiter.
package led_pkg;

  localparam int          N_REQ_DEFAULT        = 4;
  localparam logic [7:0]  IDLE_PATTERN_DEFAULT = 8'h00;
  localparam int          CNT_W                = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] win_oh_o,
  output logic [IW-1:0]    win_idx_o,
  output logic             any_o
);

  logic found;
  int   idx;

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    // Offsets 1..N_REQ so the last winner is considered last.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_i) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        win_oh_o[idx] = 1'b1;
        win_idx_o     = IW'(idx);
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter granting an 8-LED bank to one requester for a minimum tenure.
module led_bank_arbiter
  import led_pkg::*;
#(
  parameter int         N_REQ        = N_REQ_DEFAULT,
  parameter int         HOLD         = 4,
  parameter logic [7:0] IDLE_PATTERN = IDLE_PATTERN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   pat,
  output logic [N_REQ-1:0]     gnt,
  output logic [7:0]           leds,
  output logic                 active
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [7:0]         leds_q, leds_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [IW-1:0]      ptr_q;

  logic [N_REQ-1:0]   win_oh;
  logic [IW-1:0]      win_idx;
  logic               win_any;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .any_o     (win_any)
  );

  // While owned, ptr_q always holds the current owner's index.
  always_comb begin
    leds_d = IDLE_PATTERN;
    if (state_q == ST_OWN) leds_d = pat[8*int'(ptr_q) +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      leds_q  <= IDLE_PATTERN;
      cnt_q   <= '0;
      ptr_q   <= IW'(N_REQ - 1);
    end else begin
      leds_q <= leds_d;
      case (state_q)
        ST_IDLE: begin
          if (win_any) begin
            state_q <= ST_OWN;
            gnt_q   <= win_oh;
            ptr_q   <= win_idx;
            cnt_q   <= CNT_W'(HOLD - 1);
          end
        end
        ST_OWN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (win_any) begin
            gnt_q <= win_oh;
            ptr_q <= win_idx;
            cnt_q <= CNT_W'(HOLD - 1);
          end else begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign leds   = leds_q;
  assign active = |gnt_q;

endmodule
